fcu_input_buffer: RTL and testbench

Per-port input flit buffer for the NoC router, sitting directly upstream of `fcu`. It accepts flits from the link and stores them in a credit-managed FIFO. It presents the front flit plus packet context (head indication, latched destination) to the `fcu` and returns one credit upstream for every flit the `fcu` consumes. A small packet-state machine tracks head/body/tail boundaries so the `fcu` sees a stable destination for the whole packet.

---
 rtl/fcu_input_buffer_if.sv | 33 +++
 rtl/fcu_input_buffer.sv | 142 ++++++++++++++
 tb/tb_fcu_input_buffer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fcu_input_buffer_if.sv
// Link/fcu-side signal bundle for one router input port buffer.
// The buffer takes the slave view; the link and fcu side together take the master view.
interface fcu_input_buffer_if #(
    parameter int FLIT_W  = 34,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   in_valid;
    logic [FLIT_W-1:0]      in_flit;
    logic                   credit_out;
    logic                   out_valid;
    logic [FLIT_W-1:0]      out_flit;
    logic                   out_head;
    logic [2*COORD_W-1:0]   out_dest;
    logic                   out_pop;
    logic                   pkt_active;
    logic [CNT_W-1:0]       count;
    logic                   err;

    modport slave (
        input  in_valid, in_flit, out_pop,
        output credit_out, out_valid, out_flit, out_head, out_dest,
               pkt_active, count, err
    );

    modport master (
        output in_valid, in_flit, out_pop,
        input  credit_out, out_valid, out_flit, out_head, out_dest,
               pkt_active, count, err
    );
endinterface

// File: rtl/fcu_input_buffer.sv
// Credit-managed input flit FIFO with packet head/body/tail tracking for the fcu.
// Optional sticky overflow/protocol checker enabled by defining FCU_IBUF_ERR_EN.
module fcu_input_buffer #(
    parameter int FLIT_W  = 34,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fcu_input_buffer_if.slave    bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DEST_W = 2 * COORD_W;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        S_IDLE,
        S_BODY
    } state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    state_t            state_q;
    logic [DEST_W-1:0] dest_q;
    logic [FLIT_W-1:0] last_q;
    logic              credit_q;
    logic              pkt_active_q;

    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic [FLIT_W-1:0] front;
    flit_type_t        front_type;
    logic              front_is_head;

    // When empty, the front shows the most recently popped flit so out_flit holds its value.
    always_comb begin
        empty         = (count_q == '0);
        full          = (count_q == CNT_W'(DEPTH));
        front         = empty ? last_q : mem[rd_ptr];
        front_type    = flit_type_t'(front[FLIT_W-1 -: 2]);
        front_is_head = (front_type == FT_HEAD) || (front_type == FT_SINGLE);
        pop           = bus.out_pop && !empty;
        push          = bus.in_valid && (!full || pop);
    end

    // NOTE: the storage array has no reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_flit;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            dest_q       <= '0;
            last_q       <= '0;
            credit_q     <= 1'b0;
            pkt_active_q <= 1'b0;
        end else begin
            credit_q <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= front;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            // The FSM follows the popped flit type even when that type is out of protocol.
            if (pop) begin
                case (front_type)
                    FT_HEAD: begin
                        state_q      <= S_BODY;
                        pkt_active_q <= 1'b1;
                        dest_q       <= front[DEST_W-1:0];
                    end
                    FT_SINGLE, FT_TAIL: begin
                        state_q      <= S_IDLE;
                        pkt_active_q <= 1'b0;
                    end
                    default: begin
                        state_q      <= state_q;
                        pkt_active_q <= pkt_active_q;
                    end
                endcase
            end
        end
    end

`ifdef FCU_IBUF_ERR_EN
    logic err_q;
    logic drop_err;
    logic proto_err;

    always_comb begin
        drop_err  = bus.in_valid && full && !pop;
        proto_err = pop && (((state_q == S_IDLE) && !front_is_head) ||
                            ((state_q == S_BODY) &&  front_is_head));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (drop_err || proto_err) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.out_valid  = !empty;
    assign bus.out_flit   = front;
    assign bus.out_head   = !empty && (state_q == S_IDLE) && front_is_head;
    assign bus.out_dest   = (state_q == S_BODY) ? dest_q : front[DEST_W-1:0];
    assign bus.pkt_active = pkt_active_q;
    assign bus.count      = count_q;
    assign bus.credit_out = credit_q;
endmodule

// File: tb/tb_fcu_input_buffer.sv
// Directed bench for fcu_input_buffer: queue-based packet model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_fcu_input_buffer;
    localparam int FLIT_W  = 34;
    localparam int DEPTH   = 4;
    localparam int COORD_W = 3;
`ifdef FCU_IBUF_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fcu_input_buffer_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .COORD_W(COORD_W)) bus ();

    fcu_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .COORD_W(COORD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [2:0] y,
                                              input logic [2:0] x, input logic [25:0] tag);
        return {t, tag, y, x};
    endfunction

    // Packet-level model: a queue of stored flits plus "inside a packet" flag.
    logic [FLIT_W-1:0] mq[$];
    bit                m_pkt;
    logic [5:0]        m_dest;
    bit                m_err;
    bit                m_credit;
    logic [FLIT_W-1:0] m_last;
    bit                chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit do_pop;
        bit do_push;
        logic [FLIT_W-1:0] f;
        logic [1:0] tp;
        if (!rst_n) begin
            mq.delete();
            m_pkt    = 1'b0;
            m_dest   = '0;
            m_err    = 1'b0;
            m_credit = 1'b0;
            m_last   = '0;
            chk_en   = 1'b1;
        end else begin
            do_pop   = bus.out_pop && (mq.size() > 0);
            do_push  = bus.in_valid && ((mq.size() < DEPTH) || do_pop);
            m_credit = do_pop;
            if (ERR_EN && bus.in_valid && !do_push) m_err = 1'b1;
            if (do_pop) begin
                f      = mq.pop_front();
                m_last = f;
                tp     = f[FLIT_W-1 -: 2];
                if (ERR_EN && ((!m_pkt && (tp == 2'b00 || tp == 2'b10)) ||
                               ( m_pkt && (tp == 2'b01 || tp == 2'b11))))
                    m_err = 1'b1;
                if (tp == 2'b01) begin
                    m_pkt  = 1'b1;
                    m_dest = f[5:0];
                end else if (tp != 2'b00) begin
                    m_pkt = 1'b0;
                end
            end
            if (do_push) mq.push_back(bus.in_flit);
        end
    end

    always @(negedge clk) begin : compare
        bit                exp_valid;
        logic [FLIT_W-1:0] exp_front;
        if (chk_en) begin
            exp_valid = (mq.size() > 0);
            exp_front = exp_valid ? mq[0] : m_last;
            check("out_valid",  bus.out_valid,  exp_valid);
            check("count",      bus.count,      mq.size());
            check("pkt_active", bus.pkt_active, m_pkt);
            check("credit_out", bus.credit_out, m_credit);
            check("err",        bus.err,        m_err);
            check("out_head",   bus.out_head,   exp_valid && !m_pkt && exp_front[FLIT_W-2]);
            check("out_dest",   bus.out_dest,   m_pkt ? m_dest : exp_front[5:0]);
            if (exp_valid) check("out_flit", bus.out_flit, exp_front);
        end
    end

    task automatic step(input logic iv, input logic [FLIT_W-1:0] flit, input logic pop);
        bus.in_valid = iv;
        bus.in_flit  = flit;
        bus.out_pop  = pop;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_flit  = '0;
        bus.out_pop  = 1'b0;
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        check("rst_valid",  bus.out_valid,  1'b0);
        check("rst_count",  bus.count,      3'd0);
        check("rst_credit", bus.credit_out, 1'b0);
        check("rst_dest",   bus.out_dest,   6'd0);
        check("rst_err",    bus.err,        1'b0);

        // Single flit, dest x=3 y=5
        step(1'b1, mk(2'b11, 3'd5, 3'd3, 26'h1), 1'b0);
        check("single_head", bus.out_head, 1'b1);
        check("single_dest", bus.out_dest, 6'b101011);
        step(1'b0, '0, 1'b1);
        check("single_credit", bus.credit_out, 1'b1);
        check("single_idle",   bus.pkt_active, 1'b0);
        step(1'b0, '0, 1'b0);
        check("single_credit_end", bus.credit_out, 1'b0);

        // Head (x=2,y=1) + 2 body + tail, one pop per cycle
        step(1'b1, mk(2'b01, 3'd1, 3'd2, 26'h10), 1'b0);
        step(1'b1, mk(2'b00, 3'd7, 3'd7, 26'h11), 1'b1);
        check("pkt_active_head", bus.pkt_active, 1'b1);
        check("pkt_dest_head",   bus.out_dest,   6'b001010);
        step(1'b1, mk(2'b00, 3'd6, 3'd6, 26'h12), 1'b1);
        step(1'b1, mk(2'b10, 3'd4, 3'd4, 26'h13), 1'b1);
        check("pkt_dest_mid", bus.out_dest, 6'b001010);
        step(1'b0, '0, 1'b1);
        check("pkt_done",        bus.pkt_active, 1'b0);
        check("pkt_tail_credit", bus.credit_out, 1'b1);
        step(1'b0, '0, 1'b0);

        // Fill, overflow, push+pop while full, drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, mk(2'b11, 3'(i), 3'(i), 26'(32 + i)), 1'b0);
        check("full_count", bus.count, 3'd4);
        step(1'b1, mk(2'b11, 3'd0, 3'd1, 26'h99), 1'b0);
        check("drop_count", bus.count, 3'd4);
        check("drop_err",   bus.err,   ERR_EN);
        step(1'b1, mk(2'b11, 3'd2, 3'd3, 26'h77), 1'b1);
        check("full_pushpop_count", bus.count, 3'd4);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        check("drained", bus.out_valid, 1'b0);
        do_reset();

        // Streaming across pointer wrap
        step(1'b1, mk(2'b11, 3'd0, 3'd0, 26'h100), 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, mk(2'b11, 3'(i), 3'(i + 1), 26'(256 + i)), 1'b1);
            check("stream_count",  bus.count,      3'd1);
            check("stream_credit", bus.credit_out, 1'b1);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("stream_empty", bus.count, 3'd0);

        // Body at front while IDLE
        step(1'b1, mk(2'b00, 3'd1, 3'd1, 26'h200), 1'b0);
        check("body_no_head", bus.out_head, 1'b0);
        step(1'b0, '0, 1'b1);
        check("body_idle_err", bus.err,        ERR_EN);
        check("body_idle_fsm", bus.pkt_active, 1'b0);
        do_reset();

        // Reset mid-packet with 3 flits stored
        step(1'b1, mk(2'b01, 3'd3, 3'd4, 26'h300), 1'b0);
        step(1'b1, mk(2'b00, 3'd0, 3'd0, 26'h301), 1'b1);
        step(1'b1, mk(2'b00, 3'd0, 3'd0, 26'h302), 1'b0);
        step(1'b1, mk(2'b10, 3'd0, 3'd0, 26'h303), 1'b0);
        check("mid_count",  bus.count,      3'd3);
        check("mid_active", bus.pkt_active, 1'b1);
        rst_n = 1'b0;
        step(1'b0, '0, 1'b1);
        rst_n = 1'b1;
        check("mid_rst_count",  bus.count,      3'd0);
        check("mid_rst_valid",  bus.out_valid,  1'b0);
        check("mid_rst_active", bus.pkt_active, 1'b0);
        check("mid_rst_err",    bus.err,        1'b0);
        check("mid_rst_credit", bus.credit_out, 1'b0);
        step(1'b0, '0, 1'b0);
        check("mid_rst_credit2", bus.credit_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
